// File: rtl/arm_regbank.sv
// rtl/arm_regbank.sv - ARM-style register bank with CPSR flags and block transfer engine; optional REGBANK_BYPASS_EN write-to-read bypass
module arm_regbank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         read_reg_num1,
    input  logic [ADDR_W-1:0]         read_reg_num2,
    output logic [DATA_W-1:0]         read_data1,
    output logic [DATA_W-1:0]         read_data2,
    input  logic                      regwrite,
    input  logic [ADDR_W-1:0]         write_reg,
    input  logic [DATA_W-1:0]         write_data,
    input  logic                      flag_we,
    input  logic [3:0]                flags_in,
    output logic [3:0]                cpsr_flags,
    input  logic                      blk_start,
    input  logic                      blk_load,
    input  logic [(2**ADDR_W)-1:0]    blk_list,
    output logic                      blk_valid,
    input  logic                      blk_ack,
    output logic [ADDR_W-1:0]         blk_reg,
    output logic [DATA_W-1:0]         blk_rdata,
    input  logic [DATA_W-1:0]         blk_wdata,
    output logic                      blk_busy,
    output logic                      blk_done
);

    localparam int NREGS = 2**ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NREGS-1:0]   mask_q, mask_d;
    logic               load_q, load_d;
    logic [DATA_W-1:0]  regs_q [NREGS];
    logic [3:0]         flags_q;

    logic [ADDR_W-1:0]  cur_idx;
    logic [NREGS-1:0]   cur_onehot;
    logic               beat;
    logic               blk_we;

    // Priority encoder: lowest set bit of the pending mask is the next register to move
    always_comb begin
        cur_idx    = '0;
        cur_onehot = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                cur_idx = ADDR_W'(i);
            end
        end
        cur_onehot[cur_idx] = 1'b1;
    end

    assign blk_valid = (state_q == S_XFER);
    assign blk_reg   = blk_valid ? cur_idx : '0;
    assign blk_rdata = regs_q[blk_reg];
    assign blk_busy  = (state_q != S_IDLE);
    assign blk_done  = (state_q == S_DONE);
    assign beat      = blk_valid && blk_ack;
    assign blk_we    = beat && load_q;
    assign cpsr_flags = flags_q;

    // Block engine next-state: start latches list/direction, each accepted beat retires one register
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        load_d  = load_q;
        case (state_q)
            S_IDLE: begin
                if (blk_start) begin
                    if (blk_list != '0) begin
                        mask_d  = blk_list;
                        load_d  = blk_load;
                        state_d = S_XFER;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_XFER: begin
                if (beat) begin
                    mask_d = mask_q & ~cur_onehot;
                    if (mask_d == '0) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Block engine state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            load_q  <= load_d;
        end
    end

    // Register file writes; the block write comes last so it wins a same-register collision
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (regwrite) begin
                regs_q[write_reg] <= write_data;
            end
            if (blk_we) begin
                regs_q[blk_reg] <= blk_wdata;
            end
        end
    end

    // CPSR condition flags {N,Z,C,V}
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flags_q <= 4'b0000;
        end else if (flag_we) begin
            flags_q <= flags_in;
        end
    end

    // Read ports; with bypass a read of the register being written returns the incoming data
    always_comb begin
        read_data1 = regs_q[read_reg_num1];
        read_data2 = regs_q[read_reg_num2];
`ifdef REGBANK_BYPASS_EN
        if (blk_we && (read_reg_num1 == blk_reg)) begin
            read_data1 = blk_wdata;
        end else if (regwrite && (read_reg_num1 == write_reg)) begin
            read_data1 = write_data;
        end
        if (blk_we && (read_reg_num2 == blk_reg)) begin
            read_data2 = blk_wdata;
        end else if (regwrite && (read_reg_num2 == write_reg)) begin
            read_data2 = write_data;
        end
`endif
    end

endmodule

// File: tb/tb_arm_regbank.sv
// tb/tb_arm_regbank.sv - directed self-checking bench for arm_regbank
module tb_arm_regbank;

    logic        clock;
    logic        reset;
    logic [3:0]  read_reg_num1, read_reg_num2;
    logic [31:0] read_data1, read_data2;
    logic        regwrite;
    logic [3:0]  write_reg;
    logic [31:0] write_data;
    logic        flag_we;
    logic [3:0]  flags_in;
    logic [3:0]  cpsr_flags;
    logic        blk_start, blk_load;
    logic [15:0] blk_list;
    logic        blk_valid, blk_ack;
    logic [3:0]  blk_reg;
    logic [31:0] blk_rdata, blk_wdata;
    logic        blk_busy, blk_done;

    int total = 0;
    int bad   = 0;

    arm_regbank #(.DATA_W(32), .ADDR_W(4)) dut (
        .clock(clock), .reset(reset),
        .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
        .read_data1(read_data1), .read_data2(read_data2),
        .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data),
        .flag_we(flag_we), .flags_in(flags_in), .cpsr_flags(cpsr_flags),
        .blk_start(blk_start), .blk_load(blk_load), .blk_list(blk_list),
        .blk_valid(blk_valid), .blk_ack(blk_ack), .blk_reg(blk_reg),
        .blk_rdata(blk_rdata), .blk_wdata(blk_wdata),
        .blk_busy(blk_busy), .blk_done(blk_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_write(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clock);
        regwrite = 1'b1; write_reg = idx; write_data = val;
        @(negedge clock);
        regwrite = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        read_reg_num1 = 4'd15;
        #1;
        total++; if (blk_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", blk_busy); end
        total++; if (blk_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", blk_valid); end
        total++; if (blk_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", blk_done); end
        total++; if (blk_reg !== 4'd0) begin bad++; $display("FAIL rst_reg got=%h exp=0", blk_reg); end
        total++; if (cpsr_flags !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b exp=0000", cpsr_flags); end
        @(negedge clock);
        reset = 1'b1;
        do_write(4'd15, 32'hDEADBEEF);
        #1;
        total++; if (read_data1 !== 32'hDEADBEEF) begin bad++; $display("FAIL r15_write got=%h exp=deadbeef", read_data1); end
        @(negedge clock);
        flag_we = 1'b1; flags_in = 4'b1111;
        @(negedge clock);
        flag_we = 1'b0;
        #2 reset = 1'b0;
        #1;
        total++; if (read_data1 !== 32'h0) begin bad++; $display("FAIL r15_after_reset got=%h exp=0", read_data1); end
        total++; if (cpsr_flags !== 4'b0000) begin bad++; $display("FAIL flags_after_reset got=%b exp=0000", cpsr_flags); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_flags;
        @(negedge clock);
        flag_we = 1'b1; flags_in = 4'b1010;
        @(negedge clock);
        flag_we = 1'b0; flags_in = 4'b0101;
        #1;
        total++; if (cpsr_flags !== 4'b1010) begin bad++; $display("FAIL flags_load got=%b exp=1010", cpsr_flags); end
        @(negedge clock);
        #1;
        total++; if (cpsr_flags !== 4'b1010) begin bad++; $display("FAIL flags_hold got=%b exp=1010", cpsr_flags); end
    endtask

    task automatic test_readwrite;
        do_write(4'd7, 32'h7777_0007);
        do_write(4'd9, 32'h9999_0009);
        read_reg_num1 = 4'd7; read_reg_num2 = 4'd9;
        #1;
        total++; if (read_data1 !== 32'h7777_0007) begin bad++; $display("FAIL rd1_r7 got=%h exp=77770007", read_data1); end
        total++; if (read_data2 !== 32'h9999_0009) begin bad++; $display("FAIL rd2_r9 got=%h exp=99990009", read_data2); end
        @(negedge clock);
        regwrite = 1'b1; write_reg = 4'd9; write_data = 32'h1234_5678;
        read_reg_num2 = 4'd7;
        #1;
        total++; if (read_data2 !== 32'h7777_0007) begin bad++; $display("FAIL rd2_other got=%h exp=77770007", read_data2); end
        @(negedge clock);
        regwrite = 1'b0; read_reg_num1 = 4'd9;
        #1;
        total++; if (read_data1 !== 32'h1234_5678) begin bad++; $display("FAIL rd1_overwrite got=%h exp=12345678", read_data1); end
    endtask

    task automatic test_store;
        do_write(4'd1, 32'h11);
        do_write(4'd4, 32'h44);
        blk_start = 1'b1; blk_list = 16'h0012; blk_load = 1'b0; blk_ack = 1'b1;
        #1;
        total++; if (blk_busy !== 1'b0) begin bad++; $display("FAIL st_idle_busy got=%b exp=0", blk_busy); end
        @(negedge clock);
        blk_list = 16'hFFFF;
        #1;
        total++; if (blk_valid !== 1'b1) begin bad++; $display("FAIL st_b1_valid got=%b exp=1", blk_valid); end
        total++; if (blk_reg !== 4'd1) begin bad++; $display("FAIL st_b1_reg got=%h exp=1", blk_reg); end
        total++; if (blk_rdata !== 32'h11) begin bad++; $display("FAIL st_b1_data got=%h exp=11", blk_rdata); end
        total++; if (blk_busy !== 1'b1) begin bad++; $display("FAIL st_b1_busy got=%b exp=1", blk_busy); end
        @(negedge clock);
        blk_start = 1'b0;
        #1;
        total++; if (blk_reg !== 4'd4) begin bad++; $display("FAIL st_b2_reg got=%h exp=4", blk_reg); end
        total++; if (blk_rdata !== 32'h44) begin bad++; $display("FAIL st_b2_data got=%h exp=44", blk_rdata); end
        total++; if (blk_valid !== 1'b1) begin bad++; $display("FAIL st_b2_valid got=%b exp=1", blk_valid); end
        @(negedge clock);
        #1;
        total++; if (blk_done !== 1'b1) begin bad++; $display("FAIL st_done got=%b exp=1", blk_done); end
        total++; if (blk_valid !== 1'b0) begin bad++; $display("FAIL st_done_valid got=%b exp=0", blk_valid); end
        total++; if (blk_busy !== 1'b1) begin bad++; $display("FAIL st_done_busy got=%b exp=1", blk_busy); end
        @(negedge clock);
        blk_ack = 1'b0; read_reg_num1 = 4'd1;
        #1;
        total++; if (blk_done !== 1'b0) begin bad++; $display("FAIL st_done_pulse got=%b exp=0", blk_done); end
        total++; if (blk_busy !== 1'b0) begin bad++; $display("FAIL st_end_busy got=%b exp=0", blk_busy); end
        total++; if (read_data1 !== 32'h11) begin bad++; $display("FAIL st_r1_kept got=%h exp=11", read_data1); end
    endtask

    task automatic test_load_stall;
        @(negedge clock);
        blk_start = 1'b1; blk_list = 16'h8001; blk_load = 1'b1; blk_ack = 1'b0;
        @(negedge clock);
        blk_start = 1'b0;
        #1;
        total++; if (blk_reg !== 4'd0 || blk_valid !== 1'b1) begin bad++; $display("FAIL ld_stall1 got=%h/%b exp=0/1", blk_reg, blk_valid); end
        @(negedge clock);
        #1;
        total++; if (blk_reg !== 4'd0 || blk_valid !== 1'b1) begin bad++; $display("FAIL ld_stall2 got=%h/%b exp=0/1", blk_reg, blk_valid); end
        @(negedge clock);
        blk_ack = 1'b1; blk_wdata = 32'hA5A5A5A5;
        #1;
        total++; if (blk_reg !== 4'd0) begin bad++; $display("FAIL ld_b1_reg got=%h exp=0", blk_reg); end
        @(negedge clock);
        blk_wdata = 32'h5A5A5A5A; read_reg_num1 = 4'd0;
        #1;
        total++; if (blk_reg !== 4'd15) begin bad++; $display("FAIL ld_b2_reg got=%h exp=f", blk_reg); end
        total++; if (read_data1 !== 32'hA5A5A5A5) begin bad++; $display("FAIL ld_r0 got=%h exp=a5a5a5a5", read_data1); end
        @(negedge clock);
        blk_ack = 1'b0; read_reg_num1 = 4'd15;
        #1;
        total++; if (blk_done !== 1'b1) begin bad++; $display("FAIL ld_done got=%b exp=1", blk_done); end
        total++; if (read_data1 !== 32'h5A5A5A5A) begin bad++; $display("FAIL ld_r15 got=%h exp=5a5a5a5a", read_data1); end
        @(negedge clock);
    endtask

    task automatic test_collision;
        logic [31:0] exp_byp;
`ifdef REGBANK_BYPASS_EN
        exp_byp = 32'h1;
`else
        exp_byp = 32'h7;
`endif
        do_write(4'd3, 32'h7);
        blk_start = 1'b1; blk_list = 16'h0008; blk_load = 1'b1; blk_ack = 1'b1; blk_wdata = 32'h1;
        @(negedge clock);
        blk_start = 1'b0;
        regwrite = 1'b1; write_reg = 4'd3; write_data = 32'h2; read_reg_num1 = 4'd3;
        #1;
        total++; if (blk_reg !== 4'd3) begin bad++; $display("FAIL col_reg got=%h exp=3", blk_reg); end
        total++; if (read_data1 !== exp_byp) begin bad++; $display("FAIL col_bypass got=%h exp=%h", read_data1, exp_byp); end
        @(negedge clock);
        regwrite = 1'b0;
        #1;
        total++; if (read_data1 !== 32'h1) begin bad++; $display("FAIL col_commit got=%h exp=1", read_data1); end
        @(negedge clock);
        blk_start = 1'b1; blk_list = 16'h0040; blk_wdata = 32'h66;
        @(negedge clock);
        blk_start = 1'b0;
        regwrite = 1'b1; write_reg = 4'd5; write_data = 32'h55;
        @(negedge clock);
        regwrite = 1'b0; read_reg_num1 = 4'd5; read_reg_num2 = 4'd6;
        #1;
        total++; if (read_data1 !== 32'h55) begin bad++; $display("FAIL col_diff_r5 got=%h exp=55", read_data1); end
        total++; if (read_data2 !== 32'h66) begin bad++; $display("FAIL col_diff_r6 got=%h exp=66", read_data2); end
        @(negedge clock);
        blk_ack = 1'b0; blk_load = 1'b0;
    endtask

    task automatic test_empty;
        @(negedge clock);
        blk_start = 1'b1; blk_list = 16'h0000;
        @(negedge clock);
        blk_start = 1'b0;
        #1;
        total++; if (blk_done !== 1'b1) begin bad++; $display("FAIL empty_done got=%b exp=1", blk_done); end
        total++; if (blk_valid !== 1'b0) begin bad++; $display("FAIL empty_valid got=%b exp=0", blk_valid); end
        @(negedge clock);
        #1;
        total++; if (blk_done !== 1'b0 || blk_busy !== 1'b0) begin bad++; $display("FAIL empty_end got=%b/%b exp=0/0", blk_done, blk_busy); end
    endtask

    task automatic test_reset_mid;
        int done_seen;
        done_seen = 0;
        do_write(4'd2, 32'h22);
        blk_start = 1'b1; blk_list = 16'h0007; blk_load = 1'b1; blk_ack = 1'b1; blk_wdata = 32'h100;
        @(negedge clock);
        blk_start = 1'b0;
        @(negedge clock);
        blk_wdata = 32'h200; read_reg_num1 = 4'd0; read_reg_num2 = 4'd2;
        #1;
        total++; if (blk_reg !== 4'd1) begin bad++; $display("FAIL rm_second_beat got=%h exp=1", blk_reg); end
        #1 reset = 1'b0;
        #1;
        total++; if (blk_valid !== 1'b0 || blk_busy !== 1'b0 || blk_reg !== 4'd0) begin bad++; $display("FAIL rm_idle got=%b/%b/%h exp=0/0/0", blk_valid, blk_busy, blk_reg); end
        total++; if (read_data1 !== 32'h0) begin bad++; $display("FAIL rm_r0 got=%h exp=0", read_data1); end
        total++; if (read_data2 !== 32'h0) begin bad++; $display("FAIL rm_r2 got=%h exp=0", read_data2); end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1; blk_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #1;
            if (blk_done === 1'b1 || blk_busy === 1'b1) done_seen++;
        end
        total++; if (done_seen !== 0) begin bad++; $display("FAIL rm_no_done got=%0d exp=0", done_seen); end
    endtask

    initial begin
        reset = 1'b0;
        read_reg_num1 = '0; read_reg_num2 = '0;
        regwrite = 1'b0; write_reg = '0; write_data = '0;
        flag_we = 1'b0; flags_in = '0;
        blk_start = 1'b0; blk_load = 1'b0; blk_list = '0;
        blk_ack = 1'b0; blk_wdata = '0;
        test_reset;
        test_flags;
        test_readwrite;
        test_store;
        test_load_stall;
        test_collision;
        test_empty;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arm_regbank.md
ARM_REGBANK -- requirements
Module: arm_regbank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning register index width; NREGS = 2**ADDR_W registers.
REQ-003 SHALL have ports: clock  in  1  single clock, all state on rising edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: read_reg_num1, read_reg_num2  in  ADDR_W  read indices; read_data1, read_data2  out  DATA_W  read data.
REQ-006 SHALL have ports: regwrite  in  1  write enable; write_reg  in  ADDR_W  write index; write_data  in  DATA_W  write data.
REQ-007 SHALL have ports: flag_we  in  1  flag update; flags_in  in  4  {N,Z,C,V}; cpsr_flags  out  4  registered {N,Z,C,V}.
REQ-008 SHALL have ports: blk_start  in  1  start block transfer; blk_load  in  1  1 = load into regs, 0 = store out of regs; blk_list  in  NREGS  register mask.
REQ-009 SHALL have ports: blk_valid  out  1  engine beat pending; blk_ack  in  1  partner accepts beat; blk_reg  out  ADDR_W  current register; blk_rdata  out  DATA_W  store data; blk_wdata  in  DATA_W  load data.
REQ-010 SHALL have ports: blk_busy  out  1  engine active; blk_done  out  1  one-cycle completion pulse.

Function
REQ-011 SHALL return register[read_reg_numN] combinationally on read_dataN, independent of any enable.
REQ-012 SHALL write write_data to register[write_reg] on the clock edge when regwrite=1.
REQ-013 SHALL load flags_in into cpsr_flags on the clock edge when flag_we=1; otherwise hold.
REQ-014 SHALL implement block FSM states IDLE, XFER, DONE.
REQ-015 SHALL, in IDLE with blk_start=1 and blk_list!=0, latch blk_list and blk_load as pending mask and direction and enter XFER next cycle.
REQ-016 SHALL, in IDLE with blk_start=1 and blk_list=0, enter DONE next cycle with no beats.
REQ-017 SHALL in XFER assert blk_valid=1, blk_reg = lowest-set index of the pending mask, and blk_rdata = register[blk_reg].
REQ-018 SHALL complete a beat on a cycle where blk_valid=1 and blk_ack=1: clear the pending bit; if load, write blk_wdata to register[blk_reg].
REQ-019 SHALL hold blk_reg/blk_rdata stable while blk_valid=1 and blk_ack=0.
REQ-020 SHALL enter DONE on the edge that clears the last pending bit; DONE asserts blk_done=1 for exactly one cycle, then returns to IDLE.
REQ-021 SHALL assert blk_busy=1 in XFER and DONE, 0 in IDLE; blk_start SHALL be ignored while blk_busy=1.
REQ-022 SHALL, when a load beat and regwrite target the same register in the same cycle, commit the block write; different registers SHALL both commit.
REQ-023 SHALL sustain one beat per cycle when blk_ack is held high; N-register transfer takes N XFER cycles plus one DONE cycle.

Reset
REQ-024 SHALL, on reset=0, asynchronously clear all NREGS registers, cpsr_flags to 4'b0000, pending mask to 0, and force FSM to IDLE.
REQ-025 SHALL hold blk_valid=0, blk_busy=0, blk_done=0, blk_reg=0 during reset; a transfer interrupted by reset SHALL be abandoned without blk_done.

Configuration
REQ-026 SHALL use macro REGBANK_BYPASS_EN: when defined, a read index equal to the register being written that cycle (regwrite or load beat, block write per REQ-022) SHALL return the write data combinationally; when undefined, reads SHALL return the pre-write value.

Verification
REQ-027 Reset: write 0xDEADBEEF to r15, pulse reset low -> read_data1 for r15 = 0x0, cpsr_flags=0000.
REQ-028 Store: regs r1=0x11, r4=0x44, blk_list=0x0012, blk_load=0, blk_ack=1 -> beats blk_reg=1 data 0x11, then 4 data 0x44, blk_done next cycle, 3 cycles busy.
REQ-029 Load with stall: blk_list=0x8001, blk_load=1, blk_ack low 2 cycles then high, wdata 0xA5A5A5A5 then 0x5A5A5A5A -> r0=0xA5A5A5A5, r15=0x5A5A5A5A, blk_reg held at 0 during stall.
REQ-030 Collision: load beat to r3 with wdata 0x1 and regwrite r3=0x2 same cycle -> r3=0x1; read r3 same cycle returns 0x1 with REGBANK_BYPASS_EN, old value without.
REQ-031 Empty list: blk_start with blk_list=0 -> no blk_valid, blk_done high exactly one cycle after start edge.
REQ-032 Reset mid-transfer: assert reset during second of three load beats -> FSM IDLE, all regs 0, no blk_done pulse.
